tile_commit_scheduler: RTL and testbench

- Accepts background tile-map writes from two requesters: requester 0 is game logic, requester 1 is the scroll engine.
- Round-robin arbitration between them; accepted writes are buffered in a FIFO.
- Buffered writes are applied to tile-map storage only during vertical blanking, so the drawer never sees a half-updated frame.
- Also latches Mario's position once per frame, giving the drawer a frame-stable coordinate pair.

---
 rtl/tile_commit_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_tile_commit_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_commit_scheduler.sv
// tile_commit_scheduler: round-robin arbiter for background tile-map writes from game logic
// (requester 0) and the scroll engine (requester 1). Accepted writes are buffered in a FIFO
// and applied only while vblank is high, so the drawer never sees a half-updated frame.
// Mario's position is latched once per frame on the vblank rising edge.
// Optional build macro: TILE_COMMIT_STATS_EN enables the backlog_frames counter.
module tile_commit_scheduler #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAP_ROWS    = 12,
    parameter int unsigned MAP_COLS    = 17,
    parameter int unsigned MAX_COMMITS = 16
) (
    input  logic        vga_clock,
    input  logic        reset,
    input  logic        vblank,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [7:0]  req_row,
    input  logic [9:0]  req_col,
    input  logic [15:0] req_tile,
    input  logic [31:0] mario_x_in,
    input  logic [31:0] mario_y_in,
    output logic [31:0] mario_x,
    output logic [31:0] mario_y,
    output logic        tile_we,
    output logic [3:0]  tile_row,
    output logic [4:0]  tile_col,
    output logic [7:0]  tile_data,
    output logic        range_err,
    output logic        fifo_full,
    output logic [15:0] backlog_frames
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(MAX_COMMITS + 1);
    localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
    localparam logic [CW-1:0] CAP_CNT  = MAX_COMMITS[CW-1:0];

    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
        logic [7:0] tile;
    } entry_t;

    typedef enum logic {StIdle = 1'b0, StDrain = 1'b1} state_e;

    state_e        r_state;
    state_e        w_state_next;
    entry_t        r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic [CW-1:0] r_commits;
    logic          r_last_grant;
    logic          r_vblank_d;
    logic          r_range_err;
    logic [31:0]   r_mario_x;
    logic [31:0]   r_mario_y;

    logic [1:0]    w_grant;
    logic          w_sel;
    logic          w_accept;
    logic          w_in_range;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_rise;
    entry_t        w_in_entry;
    entry_t        w_head;

    // Round-robin grant: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    // Full flag comes from the registered count, so a same-cycle pop never opens ready.
    assign fifo_full = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign req_ready = reset ? 2'b00 : (w_grant & {2{~fifo_full}});
    assign w_accept  = |(req_valid & req_ready);
    assign w_sel     = w_grant[1];
    assign w_rise    = vblank & ~r_vblank_d;

    // Select the granted requester's fields and range-check them.
    always_comb begin
        w_in_entry.row  = w_sel ? req_row[7:4]   : req_row[3:0];
        w_in_entry.col  = w_sel ? req_col[9:5]   : req_col[4:0];
        w_in_entry.tile = w_sel ? req_tile[15:8] : req_tile[7:0];
        w_in_range = (32'(w_in_entry.row) < MAP_ROWS) && (32'(w_in_entry.col) < MAP_COLS);
        w_push     = w_accept & w_in_range;
    end

    // Drain FSM: the exit check happens before any pop, so the exit cycle writes nothing.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_empty || !vblank || (r_commits == CAP_CNT)) begin
                    w_state_next = StIdle;
                end else begin
                    w_pop = 1'b1;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign w_head    = r_mem[r_rptr];
    assign tile_we   = w_pop & ~reset;
    assign tile_row  = tile_we ? w_head.row  : 4'd0;
    assign tile_col  = tile_we ? w_head.col  : 5'd0;
    assign tile_data = tile_we ? w_head.tile : 8'd0;
    assign range_err = r_range_err;
    assign mario_x   = r_mario_x;
    assign mario_y   = r_mario_y;

    // Control state: FSM, FIFO pointers/occupancy, commit counter, arbiter history, latches.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_state      <= StIdle;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_commits    <= '0;
            r_last_grant <= 1'b1;
            r_vblank_d   <= 1'b0;
            r_range_err  <= 1'b0;
            r_mario_x    <= '0;
            r_mario_y    <= '0;
        end else begin
            r_state     <= w_state_next;
            r_vblank_d  <= vblank;
            r_range_err <= w_accept & ~w_in_range;
            if (w_accept) begin
                r_last_grant <= w_sel;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW+1)'(1);
            end
            if ((r_state == StIdle) && w_rise) begin
                r_commits <= '0;
            end else if (w_pop) begin
                r_commits <= r_commits + CW'(1);
            end
            if (w_rise) begin
                r_mario_x <= mario_x_in;
                r_mario_y <= mario_y_in;
            end
        end
    end

    // FIFO storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge vga_clock) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in_entry;
        end
    end

`ifdef TILE_COMMIT_STATS_EN
    logic [15:0] r_backlog;

    // Count frames whose blanking ended with writes still queued; saturating.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_backlog <= 16'd0;
        end else if (!vblank && r_vblank_d && !w_empty && (r_backlog != 16'hFFFF)) begin
            r_backlog <= r_backlog + 16'd1;
        end
    end

    assign backlog_frames = r_backlog;
`else
    assign backlog_frames = 16'd0;
`endif

endmodule

// File: tb/tb_tile_commit_scheduler.sv
// Bench for tile_commit_scheduler: directed vectors with hand-computed expectations.
// Expected tile writes are queued when issued; a negedge monitor pops and compares each
// tile_we in commit order. Built with MAX_COMMITS=4 so the commit cap is reachable.
`timescale 1ns/1ps
module tb_tile_commit_scheduler;

    typedef struct packed {
        logic [3:0] row;
        logic [4:0] col;
        logic [7:0] tile;
    } exp_t;

`ifdef TILE_COMMIT_STATS_EN
    localparam logic [31:0] BL1 = 32'd1;
`else
    localparam logic [31:0] BL1 = 32'd0;
`endif

    logic        vga_clock = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [7:0]  req_row = 8'd0;
    logic [9:0]  req_col = 10'd0;
    logic [15:0] req_tile = 16'd0;
    logic [31:0] mario_x_in = 32'd0;
    logic [31:0] mario_y_in = 32'd0;
    logic [31:0] mario_x;
    logic [31:0] mario_y;
    logic        tile_we;
    logic [3:0]  tile_row;
    logic [4:0]  tile_col;
    logic [7:0]  tile_data;
    logic        range_err;
    logic        fifo_full;
    logic [15:0] backlog_frames;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_we = 0;
    int   n_base = 0;
    exp_t exp_q[$];

    always #5 vga_clock = ~vga_clock;

    tile_commit_scheduler #(
        .FIFO_DEPTH (8),
        .MAP_ROWS   (12),
        .MAP_COLS   (17),
        .MAX_COMMITS(4)
    ) dut (
        .vga_clock     (vga_clock),
        .reset         (reset),
        .vblank        (vblank),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_row       (req_row),
        .req_col       (req_col),
        .req_tile      (req_tile),
        .mario_x_in    (mario_x_in),
        .mario_y_in    (mario_y_in),
        .mario_x       (mario_x),
        .mario_y       (mario_y),
        .tile_we       (tile_we),
        .tile_row      (tile_row),
        .tile_col      (tile_col),
        .tile_data     (tile_data),
        .range_err     (range_err),
        .fifo_full     (fifo_full),
        .backlog_frames(backlog_frames)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge vga_clock);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] row, input logic [4:0] col, input logic [7:0] tile);
        exp_t e;
        e.row  = row;
        e.col  = col;
        e.tile = tile;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int r, input logic [3:0] row, input logic [4:0] col,
                           input logic [7:0] tile);
        req_row[r*4 +: 4]  = row;
        req_col[r*5 +: 5]  = col;
        req_tile[r*8 +: 8] = tile;
    endtask

    // Present one request and expect it to be accepted in the first cycle.
    task automatic send(input int r, input logic [3:0] row, input logic [4:0] col,
                        input logic [7:0] tile, input string name);
        int waits = 0;
        set_req(r, row, col, tile);
        req_valid[r] = 1'b1;
        @(negedge vga_clock);
        while (!req_ready[r] && waits < 100) begin
            waits++;
            @(negedge vga_clock);
        end
        chk(name, 32'(waits), 32'd0);
        tick();
        req_valid[r] = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        vblank    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic frame(input int n);
        vblank = 1'b1;
        repeat (n) tick();
        vblank = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge vga_clock);
                if (tile_we) begin
                    n_we++;
                    chk("we_in_vblank", 32'(vblank), 32'd1);
                    if (exp_q.size() == 0) begin
                        chk("we_unexpected", 32'(tile_we), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("commit_row", 32'(tile_row), 32'(e.row));
                        chk("commit_col", 32'(tile_col), 32'(e.col));
                        chk("commit_data", 32'(tile_data), 32'(e.tile));
                    end
                end
            end
            begin
                #500000;
                $display("FAIL watchdog: actual=running required=finished");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state
        do_reset();
        @(negedge vga_clock);
        chk("rst_we", 32'(tile_we), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_range_err", 32'(range_err), 32'd0);
        chk("rst_mario_x", mario_x, 32'd0);
        chk("rst_backlog", 32'(backlog_frames), 32'd0);
        tick();

        // Single write: held until blanking, strobed once on the first drain cycle
        push_exp(4'd3, 5'd5, 8'd2);
        send(0, 4'd3, 5'd5, 8'd2, "t1_accept");
        repeat (3) begin
            @(negedge vga_clock);
            chk("t1_idle_we", 32'(tile_we), 32'd0);
        end
        tick();
        vblank = 1'b1;
        @(negedge vga_clock);
        chk("t1_rise_we", 32'(tile_we), 32'd0);
        @(negedge vga_clock);
        chk("t1_drain_we", 32'(tile_we), 32'd1);
        chk("t1_row", 32'(tile_row), 32'd3);
        chk("t1_col", 32'(tile_col), 32'd5);
        chk("t1_data", 32'(tile_data), 32'd2);
        @(negedge vga_clock);
        chk("t1_once", 32'(tile_we), 32'd0);
        tick();
        repeat (2) tick();
        vblank = 1'b0;
        repeat (3) tick();

        // Contention: grants alternate 0,1,0,1,0,1 starting with requester 0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_exp(4'(i / 2), 5'd1, 8'(8'h10 + i / 2));
            else            push_exp(4'(i / 2 + 4), 5'd2, 8'(8'h20 + i / 2));
        end
        begin
            int k0 = 0;
            int k1 = 0;
            set_req(0, 4'd0, 5'd1, 8'h10);
            set_req(1, 4'd4, 5'd2, 8'h20);
            req_valid = 2'b11;
            for (int i = 0; i < 6; i++) begin
                @(negedge vga_clock);
                chk("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
                tick();
                if (i % 2 == 0) begin
                    k0++;
                    set_req(0, 4'(k0), 5'd1, 8'(8'h10 + k0));
                end else begin
                    k1++;
                    set_req(1, 4'(k1 + 4), 5'd2, 8'(8'h20 + k1));
                end
            end
            req_valid = 2'b00;
        end
        // Commit cap: 6 queued, only 4 per blanking interval
        n_base = n_we;
        frame(20);
        chk("t4_cap", 32'(n_we - n_base), 32'd4);
        chk("t4_backlog", 32'(backlog_frames), BL1);
        n_base = n_we;
        frame(20);
        chk("t4_rest", 32'(n_we - n_base), 32'd2);
        chk("t4_backlog_hold", 32'(backlog_frames), BL1);

        // Full FIFO: 9th request stalls until the first drain pop is registered
        do_reset();
        for (int k = 0; k < 8; k++) begin
            push_exp(4'(k), 5'd3, 8'(8'h30 + k));
            send(0, 4'(k), 5'd3, 8'(8'h30 + k), "t3_fill");
        end
        push_exp(4'd7, 5'd16, 8'h99);
        set_req(1, 4'd7, 5'd16, 8'h99);
        req_valid[1] = 1'b1;
        @(negedge vga_clock);
        chk("t3_full", 32'(fifo_full), 32'd1);
        chk("t3_ready_full", 32'(req_ready), 32'd0);
        repeat (2) begin
            tick();
            @(negedge vga_clock);
            chk("t3_stall", 32'(req_ready), 32'd0);
        end
        n_base = n_we;
        tick();
        vblank = 1'b1;
        @(negedge vga_clock);
        chk("t3_ready_rise", 32'(req_ready), 32'd0);
        tick();
        @(negedge vga_clock);
        chk("t3_ready_pop", 32'(req_ready), 32'd0);
        tick();
        @(negedge vga_clock);
        chk("t3_ready_freed", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        repeat (17) tick();
        vblank = 1'b0;
        repeat (3) tick();
        chk("t3_frame1", 32'(n_we - n_base), 32'd4);
        frame(20);
        frame(20);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Range error: out-of-range entries pulse range_err and are dropped
        do_reset();
        n_base = n_we;
        send(1, 4'd12, 5'd0, 8'd5, "t5_accept_row");
        @(negedge vga_clock);
        chk("t5_err_row", 32'(range_err), 32'd1);
        tick();
        @(negedge vga_clock);
        chk("t5_err_pulse", 32'(range_err), 32'd0);
        tick();
        send(0, 4'd0, 5'd17, 8'd6, "t5_accept_col");
        @(negedge vga_clock);
        chk("t5_err_col", 32'(range_err), 32'd1);
        tick();
        push_exp(4'd11, 5'd16, 8'hAB);
        send(0, 4'd11, 5'd16, 8'hAB, "t5_accept_edge");
        @(negedge vga_clock);
        chk("t5_no_err_edge", 32'(range_err), 32'd0);
        tick();
        frame(6);
        chk("t5_commits", 32'(n_we - n_base), 32'd1);

        // Frame latch, then reset mid-drain with 3 entries pending
        mario_x_in = 32'd100;
        mario_y_in = 32'd50;
        do_reset();
        @(negedge vga_clock);
        chk("t6_mario_rst", mario_x, 32'd0);
        tick();
        frame(3);
        chk("t6_mario_x", mario_x, 32'd100);
        chk("t6_mario_y", mario_y, 32'd50);
        mario_x_in = 32'd120;
        for (int k = 0; k < 5; k++) begin
            push_exp(4'(k), 5'd4, 8'(8'h60 + k));
            send(0, 4'(k), 5'd4, 8'(8'h60 + k), "t6_fill");
        end
        chk("t6_mario_hold", mario_x, 32'd100);
        vblank = 1'b1;
        @(negedge vga_clock);
        chk("t6_mario_rise", mario_x, 32'd100);
        @(negedge vga_clock);
        chk("t6_mario_new", mario_x, 32'd120);
        @(negedge vga_clock);
        tick();
        reset = 1'b1;
        chk("t6_pending", 32'(exp_q.size()), 32'd3);
        @(negedge vga_clock);
        chk("t6_we_in_reset", 32'(tile_we), 32'd0);
        tick();
        reset  = 1'b0;
        vblank = 1'b0;
        exp_q.delete();
        @(negedge vga_clock);
        chk("t6_we_after", 32'(tile_we), 32'd0);
        chk("t6_full_after", 32'(fifo_full), 32'd0);
        chk("t6_mario_cleared", mario_x, 32'd0);
        tick();
        n_base = n_we;
        push_exp(4'd1, 5'd1, 8'h77);
        send(0, 4'd1, 5'd1, 8'h77, "t6_accept");
        frame(6);
        chk("t6_fresh_commit", 32'(n_we - n_base), 32'd1);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
